// File: rtl/mdclcg_pkg.sv
// Shared constants and FSM encoding for the LCG bit-collector slice.
package mdclcg_pkg;

   localparam int unsigned LCG_WIDTH = 64;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DISCARD = 2'd1,
      ST_COLLECT = 2'd2
   } state_e;

endpackage

// File: rtl/mdclcg_word_fifo.sv
// Small word FIFO with show-ahead output; push+pop while full is legal.
module mdclcg_word_fifo
   import mdclcg_pkg::*;
#(
   parameter int unsigned WORD_W     = 32,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              push,
   input  logic [WORD_W-1:0] din,
   input  logic              pop,
   output logic [WORD_W-1:0] dout,
   output logic              full,
   output logic              empty
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   logic [AW:0]       wr_ptr_q, wr_ptr_d;
   logic [AW:0]       rd_ptr_q, rd_ptr_d;
   logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
   logic [WORD_W-1:0] mem_d [FIFO_DEPTH];
   logic              do_push;
   logic              do_pop;

   // Status flags, accepted push/pop and show-ahead head word
   always_comb begin
      empty   = (wr_ptr_q == rd_ptr_q);
      full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      do_pop  = pop & ~empty;
      // when full, the slot being written is the one freed by the same-edge pop
      do_push = push & (~full | do_pop);
      dout    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   end

   // Next pointers and storage; clear dominates push/pop
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
         end
      end
   end

   // Pointer and storage registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/mdclcg_bit_collector.sv
// Derives one bit per cycle from two LCG states, drops a warm-up run and
// packs the bits MSB-first into words offered through a small FIFO.
module mdclcg_bit_collector
   import mdclcg_pkg::*;
#(
   parameter int unsigned WIDTH      = LCG_WIDTH,
   parameter int unsigned WORD_W     = 32,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned DISCARD    = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   input  logic [WIDTH-1:0]  x_state,
   input  logic [WIDTH-1:0]  y_state,
   output logic [WORD_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              overflow,
   output logic              busy
);

   localparam int unsigned BCW       = $clog2(WORD_W);
   localparam logic [BCW-1:0] LAST_BIT  = BCW'(WORD_W - 1);
   localparam logic [7:0]     DISC_INIT = 8'(DISCARD);

   state_e            state_q, state_d;
   logic [7:0]        disc_cnt_q, disc_cnt_d;
   logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [WORD_W-1:0] shreg_q, shreg_d;
   logic              overflow_q, overflow_d;

   logic              disc_en;
   logic              coll_en;
   logic              rnd_bit;
   logic [WORD_W-1:0] word;
   logic              push_req;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: start wins from any state
   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = (DISCARD == 0) ? ST_COLLECT : ST_DISCARD;
      end else begin
         case (state_q)
            ST_DISCARD: if (in_valid && disc_cnt_q == 8'd1) state_d = ST_COLLECT;
            default:    state_d = state_q;
         endcase
      end
   end

   // FSM outputs: busy flag and per-state sampling enables
   always_comb begin
      busy    = (state_q != ST_IDLE);
      disc_en = (state_q == ST_DISCARD) && in_valid && !start;
      coll_en = (state_q == ST_COLLECT) && in_valid && !start;
   end

   // Bit generation, shifting, counters and overflow tracking
   always_comb begin
      rnd_bit    = (x_state > y_state);
      word       = {shreg_q[WORD_W-2:0], rnd_bit};
      pop        = out_valid & out_ready;
      push_req   = 1'b0;
      disc_cnt_d = disc_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shreg_d    = shreg_q;
      overflow_d = overflow_q;
      if (start) begin
         disc_cnt_d = DISC_INIT;
         bit_cnt_d  = '0;
         shreg_d    = '0;
         overflow_d = 1'b0;
      end else begin
         if (disc_en) begin
            disc_cnt_d = disc_cnt_q - 8'd1;
         end
         if (coll_en) begin
            shreg_d   = word;
            bit_cnt_d = bit_cnt_q + BCW'(1);
            if (bit_cnt_q == LAST_BIT) begin
               push_req = 1'b1;
               if (fifo_full && !pop) begin
                  overflow_d = 1'b1;
               end
            end
         end
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disc_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shreg_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         disc_cnt_q <= disc_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shreg_q    <= shreg_d;
         overflow_q <= overflow_d;
      end
   end

   mdclcg_word_fifo #(
      .WORD_W     (WORD_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (start),
      .push  (push_req),
      .din   (word),
      .pop   (pop),
      .dout  (out_data),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Port-level outputs
   always_comb begin
      out_valid = ~fifo_empty;
      overflow  = overflow_q;
   end

endmodule

// File: tb/tb_mdclcg_bit_collector.sv
// Directed bench for mdclcg_bit_collector with default parameters.
module tb_mdclcg_bit_collector;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        in_valid;
   logic [63:0] x_state;
   logic [63:0] y_state;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        overflow;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [31:0] A0 = 32'h1234_5678;
   localparam logic [31:0] A1 = 32'h9ABC_DEF0;
   localparam logic [31:0] A2 = 32'h0F0F_0F0F;
   localparam logic [31:0] A3 = 32'hC3C3_3C3C;
   localparam logic [31:0] A4 = 32'hDEAD_BEEF;
   localparam logic [31:0] A5 = 32'h5A5A_A5A5;

   mdclcg_bit_collector #(
      .WIDTH      (64),
      .WORD_W     (32),
      .FIFO_DEPTH (4),
      .DISCARD    (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_valid  (in_valid),
      .x_state   (x_state),
      .y_state   (y_state),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overflow  (overflow),
      .busy      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_bit(input logic b);
      if (b) begin
         x_state = 64'd9;
         y_state = 64'd4;
      end else begin
         x_state = 64'd4;
         y_state = 64'd9;
      end
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic collect_word(input logic [31:0] w, input logic pop_last);
      for (int k = 0; k < 32; k++) begin
         set_bit(w[31-k]);
         out_ready = pop_last && (k == 31);
         tick();
      end
      out_ready = 1'b0;
   endtask

   task automatic pop_expect(input string tag, input logic [31:0] exp);
      check_eq(tag, {63'd0, out_valid}, 64'd1);
      check_eq(tag, {32'd0, out_data}, {32'd0, exp});
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      x_state   = 64'd5;
      y_state   = 64'd3;
      tick();
      tick();
      check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check_eq("rst_out_data",  {32'd0, out_data},  64'd0);
      check_eq("rst_overflow",  {63'd0, overflow},  64'd0);
      check_eq("rst_busy",      {63'd0, busy},      64'd0);
      rst_n = 1'b1;

      // idle with x>y and no start: nothing happens
      for (int i = 0; i < 40; i++) tick();
      check_eq("idle_out_valid", {63'd0, out_valid}, 64'd0);
      check_eq("idle_busy",      {63'd0, busy},      64'd0);

      // all-ones word, latency 8+32 edges after the start edge
      out_ready = 1'b1;
      set_bit(1'b1);
      do_start();
      check_eq("start_busy", {63'd0, busy}, 64'd1);
      for (int i = 1; i <= 40; i++) begin
         if (i == 39) check_eq("ones_valid_early", {63'd0, out_valid}, 64'd0);
         tick();
      end
      check_eq("ones_valid", {63'd0, out_valid}, 64'd1);
      check_eq("ones_data",  {32'd0, out_data},  64'hFFFF_FFFF);

      // alternating pattern with x==y on the first collected bit
      out_ready = 1'b0;
      do_start();
      check_eq("restart_clears_fifo", {63'd0, out_valid}, 64'd0);
      for (int i = 0; i < 8; i++) tick();
      for (int k = 0; k < 32; k++) begin
         if (k == 0) begin
            x_state = 64'd7;
            y_state = 64'd7;
         end else begin
            set_bit((k % 2) == 0);
         end
         tick();
      end
      check_eq("alt_valid", {63'd0, out_valid}, 64'd1);
      check_eq("alt_data",  {32'd0, out_data},  64'h2AAA_AAAA);

      // fill, overflow, then accept a push on a same-edge pop
      do_start();
      for (int i = 0; i < 8; i++) tick();
      collect_word(A0, 1'b0);
      collect_word(A1, 1'b0);
      collect_word(A2, 1'b0);
      collect_word(A3, 1'b0);
      check_eq("fill_overflow", {63'd0, overflow}, 64'd0);
      check_eq("fill_head",     {32'd0, out_data}, {32'd0, A0});
      collect_word(A4, 1'b0);
      check_eq("drop_overflow", {63'd0, overflow}, 64'd1);
      check_eq("drop_head",     {32'd0, out_data}, {32'd0, A0});
      collect_word(A5, 1'b1);
      check_eq("pushpop_overflow", {63'd0, overflow}, 64'd1);
      in_valid = 1'b0;
      pop_expect("drain_1", A1);
      pop_expect("drain_2", A2);
      pop_expect("drain_3", A3);
      pop_expect("drain_5", A5);
      check_eq("drained_valid",    {63'd0, out_valid}, 64'd0);
      check_eq("drained_overflow", {63'd0, overflow},  64'd1);

      // mid-word start with two words buffered; start beats the pop
      in_valid = 1'b1;
      collect_word(A0, 1'b0);
      collect_word(A1, 1'b0);
      set_bit(1'b1);
      for (int i = 0; i < 5; i++) tick();
      check_eq("partial_bit_cnt", {59'd0, dut.bit_cnt_q}, 64'd5);
      start     = 1'b1;
      out_ready = 1'b1;
      tick();
      start     = 1'b0;
      out_ready = 1'b0;
      check_eq("flush_valid",    {63'd0, out_valid}, 64'd0);
      check_eq("flush_overflow", {63'd0, overflow},  64'd0);
      check_eq("flush_bit_cnt",  {59'd0, dut.bit_cnt_q}, 64'd0);
      check_eq("flush_disc_cnt", {56'd0, dut.disc_cnt_q}, 64'd8);
      for (int i = 1; i <= 40; i++) begin
         if (i == 39) check_eq("reflush_valid_early", {63'd0, out_valid}, 64'd0);
         tick();
      end
      check_eq("reflush_valid", {63'd0, out_valid}, 64'd1);
      check_eq("reflush_data",  {32'd0, out_data},  64'hFFFF_FFFF);

      // in_valid toggling freezes counters on the idle cycles
      set_bit(1'b0);
      for (int i = 0; i < 10; i++) begin
         in_valid = ((i % 2) == 0);
         tick();
      end
      check_eq("toggle_bit_cnt", {59'd0, dut.bit_cnt_q}, 64'd5);
      check_eq("toggle_shreg",   {32'd0, dut.shreg_q},   64'hFFFF_FFE0);
      in_valid = 1'b0;
      tick();
      check_eq("hold_bit_cnt", {59'd0, dut.bit_cnt_q}, 64'd5);
      check_eq("pre_rst_valid", {63'd0, out_valid}, 64'd1);

      // asynchronous reset between edges
      in_valid = 1'b1;
      rst_n = 1'b0;
      #2;
      check_eq("async_out_valid", {63'd0, out_valid}, 64'd0);
      check_eq("async_out_data",  {32'd0, out_data},  64'd0);
      check_eq("async_overflow",  {63'd0, overflow},  64'd0);
      check_eq("async_busy",      {63'd0, busy},      64'd0);
      check_eq("async_bit_cnt",   {59'd0, dut.bit_cnt_q}, 64'd0);
      #2;
      rst_n = 1'b1;
      tick();
      check_eq("post_rst_busy",  {63'd0, busy},      64'd0);
      check_eq("post_rst_valid", {63'd0, out_valid}, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
